// File: rtl/imem_ctrl.sv
// Instruction-memory controller: block fetch with one-entry line buffer,
// round-robin read/write arbitration, block writes with buffer invalidation.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rd_req/rd_addr -> rd_gnt         fetch request / one-cycle grant
//   rd_valid, rd_data0/1             fetched block pair, one-cycle valid
//   wr_req/wr_addr/wr_data -> wr_gnt block-write request / grant
//   wr_done                          one-cycle write completion
//   mem_addr/mem_rd/mem_wr/mem_wdata memory command port
//   mem_out1/mem_out2                memory data, valid cycle after mem_rd
//   busy                             high whenever not IDLE
module imem_ctrl #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int ALIGN  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [WORD_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [BLK_W-1:0]  rd_data0,
  output logic [BLK_W-1:0]  rd_data1,
  input  logic              wr_req,
  input  logic [WORD_W-1:0] wr_addr,
  input  logic [BLK_W-1:0]  wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_out1,
  input  logic [BLK_W-1:0]  mem_out2,
  output logic              busy
);

  localparam logic [WORD_W-1:0] BLK_MASK =
    {WORD_W{1'b1}} << ALIGN;
  localparam logic [WORD_W-1:0] BLK_STEP =
    WORD_W'(1) << ALIGN;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP,
    WR_ISSUE,
    WR_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic              last_wr;
  logic              tag_vld;
  logic [WORD_W-1:0] tag;
  logic [WORD_W-1:0] rd_blk;
  logic [WORD_W-1:0] wr_blk;
  logic              idle;
  logic              pick_rd;
  logic              pick_wr;
  logic              rd_hit;
  logic              wr_inv;

  assign rd_blk = rd_addr & BLK_MASK;
  assign wr_blk = wr_addr & BLK_MASK;
  assign idle   = (state == IDLE);

  // On a tie the side that did not win last time is served.
  assign pick_rd = idle & rd_req
                 & (~wr_req | last_wr);
  assign pick_wr = idle & wr_req
                 & (~rd_req | ~last_wr);

  assign rd_hit = tag_vld & (rd_blk == tag);

  // A write to the buffered block or its pair block stales the buffer.
  assign wr_inv = (mem_addr == tag)
                | (mem_addr == tag + BLK_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_wr <= 1'b1;
    end else begin
      state <= state_nx;
      if (pick_rd) begin
        last_wr <= 1'b0;
      end else if (pick_wr) begin
        last_wr <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    rd_valid = 1'b0;
    wr_done  = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy   = 1'b0;
        rd_gnt = pick_rd & rst_n;
        wr_gnt = pick_wr & rst_n;
        unique case (1'b1)
          pick_rd:
            state_nx = rd_hit ? RD_RESP
                              : RD_ISSUE;
          pick_wr:
            state_nx = WR_ISSUE;
          default: ;
        endcase
      end
      RD_ISSUE: begin
        mem_rd   = 1'b1;
        state_nx = RD_CAPT;
      end
      RD_CAPT: begin
        state_nx = RD_RESP;
      end
      RD_RESP: begin
        rd_valid = 1'b1;
        state_nx = IDLE;
      end
      WR_ISSUE: begin
        mem_wr   = 1'b1;
        state_nx = WR_RESP;
      end
      WR_RESP: begin
        wr_done  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // mem_addr only moves when a memory access will follow,
  // so a buffer hit leaves the memory port untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data0  <= '0;
      rd_data1  <= '0;
      tag       <= '0;
      tag_vld   <= 1'b0;
    end else begin
      if (pick_rd && !rd_hit) begin
        mem_addr <= rd_blk;
      end else if (pick_wr) begin
        mem_addr  <= wr_blk;
        mem_wdata <= wr_data;
      end
      if (state == RD_CAPT) begin
        rd_data0 <= mem_out1;
        rd_data1 <= mem_out2;
        tag      <= mem_addr;
        tag_vld  <= 1'b1;
      end
      if (state == WR_ISSUE && wr_inv) begin
        tag_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: memory model, scoreboard queues,
// latency/arbitration/invalidation/reset scenarios.
module tb_imem_ctrl;

  localparam logic [31:0] MASK = 32'hFFFF_FF80;
  localparam logic [31:0] STEP = 32'h0000_0080;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_gnt;
  logic         rd_valid;
  logic [127:0] rd_data0;
  logic [127:0] rd_data1;
  logic         wr_req = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         wr_gnt;
  logic         wr_done;
  logic [31:0]  mem_addr;
  logic         mem_rd;
  logic         mem_wr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_out1 = '0;
  logic [127:0] mem_out2 = '0;
  logic         busy;

  always #5 clk = ~clk;

  imem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .wr_done   (wr_done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_out1  (mem_out1),
    .mem_out2  (mem_out2),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] rq [$];
  logic [159:0] wq [$];
  logic [127:0] refm [logic [31:0]];
  logic [127:0] memm [logic [31:0]];

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(
    input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_C3C3, a + 32'd1};
  endfunction

  function automatic logic [127:0] ref_rd(
    input logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return pat(a);
  endfunction

  function automatic logic [127:0] mem_get(
    input logic [31:0] a);
    if (memm.exists(a)) return memm[a];
    return pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) memm[mem_addr] = mem_wdata;
    if (mem_rd) begin
      mem_out1 <= mem_get(mem_addr);
      mem_out2 <= mem_get(mem_addr + STEP);
    end
  end

  logic         prev_op = 1'b0;
  logic [255:0] re;
  logic [159:0] we;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (rq.size() == 0) begin
        check("rd_unexpected", 128'd1, 128'd0);
      end else begin
        re = rq.pop_front();
        check("rd_data0", rd_data0, re[127:0]);
        check("rd_data1", rd_data1, re[255:128]);
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", 128'd1, 128'd0);
      end else begin
        we = wq.pop_front();
        check("wr_maddr", 128'(mem_addr),
              128'(we[159:128]));
        check("wr_mdata", mem_wdata, we[127:0]);
      end
    end
    if (mem_rd || mem_wr) begin
      check("mem_gap",
            128'({prev_op, mem_rd & mem_wr}),
            128'd0);
    end
    prev_op = mem_rd | mem_wr;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic gr,
                          output logic gw,
                          output int w);
    w = 0;
    while (!(rd_gnt || wr_gnt) && w < 50) begin
      tick;
      w++;
    end
    gr = rd_gnt;
    gw = wr_gnt;
    if (!(gr || gw))
      check("gnt_timeout", 128'd0, 128'd1);
  endtask

  task automatic do_reset;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_rd_gnt", 128'(rd_gnt), 128'd0);
    check("rst_wr_gnt", 128'(wr_gnt), 128'd0);
    check("rst_rd_valid", 128'(rd_valid), 128'd0);
    check("rst_wr_done", 128'(wr_done), 128'd0);
    check("rst_mem_rd", 128'(mem_rd), 128'd0);
    check("rst_mem_wr", 128'(mem_wr), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rd_data0", rd_data0, 128'd0);
    check("rst_rd_data1", rd_data1, 128'd0);
    check("rst_mem_addr", 128'(mem_addr), 128'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic rd_txn(input logic [31:0] a,
                        input bit hit,
                        input bit keep,
                        output int w);
    logic [31:0] b;
    logic gr, gw;
    int n, nrd;
    b = a & MASK;
    rd_addr = a;
    rd_req = 1'b1;
    #1;
    wait_gnt(gr, gw, w);
    check("rd_gnt", 128'(gr), 128'd1);
    check("rd_gnt_busy", 128'(busy), 128'd0);
    rq.push_back({ref_rd(b + STEP), ref_rd(b)});
    n = 0;
    nrd = 0;
    do begin
      tick;
      n++;
      if (n == 1) begin
        check("busy_up", 128'(busy), 128'd1);
        rd_addr = 32'hDEAD_BEEF;
        if (!keep) rd_req = 1'b0;
      end
      if (mem_rd) begin
        nrd++;
        check("rd_maddr", 128'(mem_addr), 128'(b));
      end
    end while (!rd_valid && n < 20);
    check("rd_latency", 128'(n),
          hit ? 128'd1 : 128'd3);
    check("rd_mem_rd_cnt", 128'(nrd),
          hit ? 128'd0 : 128'd1);
  endtask

  task automatic wr_txn(input logic [31:0] a,
                        input logic [127:0] d);
    logic [31:0] b;
    logic gr, gw;
    int w, n, nwr;
    b = a & MASK;
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    #1;
    wait_gnt(gr, gw, w);
    check("wr_gnt", 128'(gw), 128'd1);
    check("wr_not_rd", 128'(gr), 128'd0);
    wq.push_back({b, d});
    refm[b] = d;
    n = 0;
    nwr = 0;
    do begin
      tick;
      n++;
      if (n == 1) begin
        wr_req = 1'b0;
        wr_data = ~d;
        wr_addr = ~a;
      end
      if (mem_wr) nwr++;
    end while (!wr_done && n < 20);
    check("wr_latency", 128'(n), 128'd2);
    check("wr_mem_wr_cnt", 128'(nwr), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gr, gw;
    int w;
    logic [31:0] a;

    do_reset;

    rd_txn(32'h0000_0084, 1'b0, 1'b0, w);
    rd_txn(32'h0000_00F0, 1'b1, 1'b0, w);

    wr_txn(32'h0000_0000, {4{32'h1111_0000}});
    rd_txn(32'h0000_0080, 1'b1, 1'b0, w);
    wr_txn(32'h0000_0184, {4{32'h2222_0000}});
    rd_txn(32'h0000_0088, 1'b1, 1'b0, w);
    wr_txn(32'h0000_0100, {4{32'h3333_0000}});
    rd_txn(32'h0000_0080, 1'b0, 1'b0, w);

    rd_addr = 32'h0000_0580;
    rd_req = 1'b1;
    #1;
    wait_gnt(gr, gw, w);
    check("capt_gnt", 128'(gr), 128'd1);
    tick;
    rd_req = 1'b0;
    check("capt_mem_rd", 128'(mem_rd), 128'd1);
    tick;
    do_reset;
    tick;
    rd_txn(32'h0000_0580, 1'b0, 1'b0, w);
    rd_txn(32'h0000_0080, 1'b0, 1'b0, w);

    do_reset;
    rd_addr = 32'h0000_0200;
    wr_addr = 32'h0000_0300;
    wr_data = {4{32'hAAAA_5555}};
    rd_req = 1'b1;
    wr_req = 1'b1;
    #1;
    wait_gnt(gr, gw, w);
    check("tie1_rd", 128'(gr), 128'd1);
    check("tie1_wr", 128'(gw), 128'd0);
    rq.push_back({ref_rd(32'h280), ref_rd(32'h200)});
    tick;
    wait_gnt(gr, gw, w);
    check("tie2_wr", 128'(gw), 128'd1);
    check("tie2_rd", 128'(gr), 128'd0);
    wq.push_back({32'h300, {4{32'hAAAA_5555}}});
    refm[32'h300] = {4{32'hAAAA_5555}};
    tick;
    wait_gnt(gr, gw, w);
    check("tie3_rd", 128'(gr), 128'd1);
    check("tie3_wr", 128'(gw), 128'd0);
    rq.push_back({ref_rd(32'h280), ref_rd(32'h200)});
    tick;
    rd_req = 1'b0;
    wr_data = {4{32'h5555_AAAA}};
    wait_gnt(gr, gw, w);
    check("tie4_wr", 128'(gw), 128'd1);
    wq.push_back({32'h300, {4{32'h5555_AAAA}}});
    refm[32'h300] = {4{32'h5555_AAAA}};
    tick;
    wr_req = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      tick;
      w++;
    end

    for (int i = 0; i < 10; i++) begin
      a = 32'h4000 + 32'((i / 2) * 128)
        + 32'((i % 2) * 4);
      rd_txn(a, (i % 2) == 1, 1'b1, w);
      if (i > 0)
        check("idle_gap", 128'(w), 128'd1);
    end
    rd_req = 1'b0;

    w = 0;
    while (busy && w < 20) begin
      tick;
      w++;
    end
    tick;
    check("rq_left", 128'(rq.size()), 128'd0);
    check("wq_left", 128'(wq.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
